// File: rtl/manchester_tx.sv
// manchester_tx: framed Manchester (IEEE 802.3 polarity) line transmitter.
// Accepts one word per tx_valid/tx_ready handshake and serialises it MSB first
// as: PREAMBLE_BITS '1' bits, DATA_WIDTH data bits, then one idle gap bit.
// Bit 1 = half-bit low then half-bit high; bit 0 = half-bit high then low.
//
// Ports:
//   clock           system clock, all logic on posedge
//   reset           synchronous, active-high
//   tx_data         word to send, sampled only on the handshake edge
//   tx_valid        tx_data is valid
//   tx_ready        idle and able to accept a word
//   manchester_out  encoded line output, idles low
//   busy            high while a frame (preamble, data or gap) is in progress
//   frame_done      one-cycle pulse on the last cycle of the gap
module manchester_tx #(
  parameter int unsigned HALF_PERIOD   = 10,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PREAMBLE_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  manchester_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned HALF_W   = $clog2(HALF_PERIOD);
  localparam int unsigned BIT_MAX  = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int unsigned BIT_W    = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int unsigned PRE_LAST = (PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0;

  localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(HALF_PERIOD - 1);
  localparam logic [HALF_W-1:0] HALF_PENULT = HALF_W'(HALF_PERIOD - 2);
  localparam logic [BIT_W-1:0]  PRE_LAST_B  = BIT_W'(PRE_LAST);
  localparam logic [BIT_W-1:0]  DATA_LAST_B = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t                state;
  logic [HALF_W-1:0]     half_cnt;
  logic                  phase;      // 0 = first half of bit, 1 = second half
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  half_end_c;
  logic                  cur_bit_c;
  logic [DATA_WIDTH-1:0] shift_next_c;

  // Half-bit boundary, bit currently on the line, and the word after one shift
  assign half_end_c   = (half_cnt == HALF_LAST);
  assign cur_bit_c    = (state == PREAMBLE) ? 1'b1 : shreg[DATA_WIDTH-1];
  assign shift_next_c = shreg << 1;

  // Frame sequencer; manchester_out is loaded with the level of the half-bit
  // that starts on the next cycle, so the line only moves on half-bit edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      half_cnt       <= '0;
      phase          <= 1'b0;
      bit_cnt        <= '0;
      shreg          <= '0;
      tx_ready       <= 1'b0;
      manchester_out <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          busy           <= 1'b0;
          manchester_out <= 1'b0;
          half_cnt       <= '0;
          phase          <= 1'b0;
          bit_cnt        <= '0;
          if (tx_ready && tx_valid) begin
            shreg    <= tx_data;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            if (PREAMBLE_BITS > 0) begin
              state          <= PREAMBLE;
              manchester_out <= 1'b0;  // first half of a '1' bit
            end else begin
              state          <= DATA;
              manchester_out <= ~tx_data[DATA_WIDTH-1];
            end
          end else begin
            tx_ready <= 1'b1;
          end
        end

        PREAMBLE, DATA: begin
          if (!half_end_c) begin
            half_cnt <= half_cnt + HALF_W'(1);
          end else begin
            half_cnt <= '0;
            if (!phase) begin
              // Mid-bit: second half carries the bit value itself
              phase          <= 1'b1;
              manchester_out <= cur_bit_c;
            end else begin
              phase <= 1'b0;
              if (state == PREAMBLE) begin
                if (bit_cnt == PRE_LAST_B) begin
                  state          <= DATA;
                  bit_cnt        <= '0;
                  manchester_out <= ~shreg[DATA_WIDTH-1];
                end else begin
                  bit_cnt        <= bit_cnt + BIT_W'(1);
                  manchester_out <= 1'b0;
                end
              end else begin
                shreg <= shift_next_c;
                if (bit_cnt == DATA_LAST_B) begin
                  state          <= GAP;
                  bit_cnt        <= '0;
                  manchester_out <= 1'b0;
                end else begin
                  bit_cnt        <= bit_cnt + BIT_W'(1);
                  manchester_out <= ~shift_next_c[DATA_WIDTH-1];
                end
              end
            end
          end
        end

        GAP: begin
          manchester_out <= 1'b0;
          if (!half_end_c) begin
            half_cnt   <= half_cnt + HALF_W'(1);
            // Registered pulse lands on the final gap cycle
            frame_done <= phase && (half_cnt == HALF_PENULT);
          end else begin
            half_cnt <= '0;
            if (phase) begin
              state    <= IDLE;
              phase    <= 1'b0;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              phase <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// tb_manchester_tx: directed self-checking bench for manchester_tx.
// Checks the line waveform cycle by cycle against a bit-level model, the
// handshake/busy/frame_done timing, mid-frame reset, a short-period
// no-preamble instance, and decodes a frame back from the captured line.
module tb_manchester_tx;

  localparam int HP    = 10;
  localparam int PB    = 8;
  localparam int DW    = 8;
  localparam int FRAME = (PB + DW + 1) * 2 * HP;  // 340
  localparam int HP2   = 2;
  localparam int FRAME2 = (0 + 8 + 1) * 2 * HP2;  // 36

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       manchester_out;
  logic       busy;
  logic       frame_done;

  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       manchester_out2;
  logic       busy2;
  logic       frame_done2;

  int n_checks = 0;
  int n_pass   = 0;
  logic cap [1:FRAME];

  manchester_tx #(.HALF_PERIOD(HP), .DATA_WIDTH(DW), .PREAMBLE_BITS(PB)) dut (
    .clock          (clock),
    .reset          (reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .manchester_out (manchester_out),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  manchester_tx #(.HALF_PERIOD(HP2), .DATA_WIDTH(8), .PREAMBLE_BITS(0)) dut2 (
    .clock          (clock),
    .reset          (reset),
    .tx_data        (tx_data2),
    .tx_valid       (tx_valid2),
    .tx_ready       (tx_ready2),
    .manchester_out (manchester_out2),
    .busy           (busy2),
    .frame_done     (frame_done2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected line level in cycle k (1 = first cycle after the handshake edge)
  function automatic logic exp_line(input logic [7:0] w, input int k, input int hp,
                                    input int p, input int d);
    int   h;
    int   b;
    logic bv;
    h = (k - 1) / hp;
    b = h / 2;
    if (b < p) bv = 1'b1;
    else if (b < p + d) bv = w[3'(d - 1 - (b - p))];
    else return 1'b0;
    return ((h % 2) == 0) ? ~bv : bv;
  endfunction

  // Checks {busy, tx_ready, frame_done, line} for ncyc cycles of a frame on dut;
  // a full frame also checks the following idle cycle.
  task automatic run_frame(input logic [7:0] w, input int ncyc, input bit scramble);
    for (int k = 1; k <= ncyc; k++) begin
      cap[k] = manchester_out;
      check($sformatf("frame_%02h_cyc%0d", w, k),
            32'({busy, tx_ready, frame_done, manchester_out}),
            32'({1'b1, 1'b0, 1'(k == FRAME), exp_line(w, k, HP, PB, DW)}));
      if (scramble) tx_data = 8'($urandom);
      if (k < ncyc) tick();
    end
    if (ncyc == FRAME) begin
      tick();
      check($sformatf("idle_after_%02h", w),
            32'({busy, tx_ready, frame_done, manchester_out}), 32'(4'b0100));
    end
  endtask

  initial begin
    int         quiet_bad;
    int         miss;
    logic [7:0] dec;

    reset     = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'hFF;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;

    // Reset held 3 cycles with a pending word
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_state_%0d", i),
            32'({busy, tx_ready, frame_done, manchester_out}), 32'(4'b0000));
    end
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'({busy, tx_ready, frame_done, manchester_out}), 32'(4'b0100));
    tick();  // handshake edge for 8'hFF
    tx_valid = 1'b0;
    run_frame(8'hFF, FRAME, 1'b0);

    // Single frame with default parameters
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    tx_valid = 1'b0;
    run_frame(8'hA5, FRAME, 1'b0);

    // Back-to-back with tx_valid held and tx_data scrambled while busy
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    run_frame(8'h00, FRAME, 1'b1);
    tx_data = 8'hFF;
    tick();
    run_frame(8'hFF, FRAME, 1'b1);
    tx_valid = 1'b0;

    // Reset during DATA bit 3, second half (cycle 235 of the frame)
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tick();
    tx_valid = 1'b0;
    run_frame(8'h5A, 235, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_frame_reset", 32'({busy, tx_ready, frame_done, manchester_out}), 32'(4'b0000));
    reset = 1'b0;
    tick();
    check("ready_after_mid_reset", 32'({busy, tx_ready, frame_done, manchester_out}), 32'(4'b0100));
    quiet_bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (busy || frame_done || manchester_out || !tx_ready) quiet_bad++;
    end
    check("no_frame_done_after_reset", 32'(quiet_bad), 32'(0));
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tick();
    tx_valid = 1'b0;
    run_frame(8'h3C, FRAME, 1'b0);

    // Loopback: decode 8'hC3 and check recovered-clock transitions
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    run_frame(8'hC3, FRAME, 1'b0);
    dec = 8'h00;
    for (int i = 0; i < DW; i++) begin
      dec = {dec[6:0], cap[(2 * (PB + i) + 1) * HP + HP / 2 + 1]};
    end
    check("loopback_decoded_word", 32'(dec), 32'(8'hC3));
    miss = 0;
    for (int h = 1; h < 2 * (PB + DW); h++) begin
      if ((h < 2 * PB || (h % 2) == 1) && cap[h * HP] == cap[h * HP + 1]) miss++;
    end
    check("loopback_half_bit_edges", 32'(miss), 32'(0));

    // HALF_PERIOD=2, no preamble, word 8'h80
    check("dut2_idle_ready", 32'({busy2, tx_ready2, frame_done2, manchester_out2}), 32'(4'b0100));
    tx_valid2 = 1'b1;
    tx_data2  = 8'h80;
    tick();
    tx_valid2 = 1'b0;
    for (int k = 1; k <= FRAME2; k++) begin
      check($sformatf("dut2_frame_cyc%0d", k),
            32'({busy2, tx_ready2, frame_done2, manchester_out2}),
            32'({1'b1, 1'b0, 1'(k == FRAME2), exp_line(8'h80, k, HP2, 0, 8)}));
      if (k < FRAME2) tick();
    end
    tick();
    check("dut2_idle_after", 32'({busy2, tx_ready2, frame_done2, manchester_out2}), 32'(4'b0100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
